// File: rtl/aes_dom_pkg.sv
// Shared definitions for the masked SubBytes sequencer: FSM encoding,
// byte count of an AES state and share/byte bit-position helper.
package aes_dom_pkg;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Bit offset of byte b of share s inside a packed 128*SHARES state vector.
    function automatic int byte_lsb(input int s, input int b);
        return 128 * s + 8 * b;
    endfunction

endpackage

// File: rtl/valid_pipe.sv
// Valid-bit shift register matching the sbox pipeline depth; the tap marks
// the cycle in which the sbox output for a fed byte is present.
module valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_tap,
    output logic o_any
);

    logic [DEPTH-1:0] r_sh;

    // Shift a token in every cycle; cleared by reset so aborted runs leave nothing in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sh <= '0;
        end else begin
            r_sh[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign o_tap = r_sh[DEPTH-1];
    assign o_any = |r_sh;

endmodule

// File: rtl/masked_subbytes_seq.sv
// Masked SubBytes sequencer: streams the 16 bytes of a shared AES state into
// an external pipelined DOM sbox and reassembles the shared results.
// Shares are only ever moved, never combined with each other.
module masked_subbytes_seq
    import aes_dom_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 4
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    StartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    output logic                    ReadyxSO,
    output logic                    DonexSO,
    output logic [128*SHARES-1:0]   StatexDO,
    output logic [8*SHARES-1:0]     SboxXxDO,
    input  logic [8*SHARES-1:0]     SboxQxDI,
    output logic                    RndEnxSO
);

    seq_state_t              r_state;
    logic [3:0]              r_in_cnt;
    logic [3:0]              r_out_cnt;
    logic [128*SHARES-1:0]   r_in;
    logic [128*SHARES-1:0]   r_res;
    logic                    r_ready;
    logic                    r_done;
    logic                    w_vld_in;
    logic                    w_vld_tap;
    logic                    w_vld_any;
    logic                    w_accept;

    assign w_accept = (r_state == ST_IDLE) && StartxSI;
    assign w_vld_in = (r_state == ST_FEED);

    valid_pipe #(
        .DEPTH (SBOX_LATENCY)
    ) u_valid_pipe (
        .i_clk   (ClkxCI),
        .i_rst_n (RstxBI),
        .i_d     (w_vld_in),
        .o_tap   (w_vld_tap),
        .o_any   (w_vld_any)
    );

    // Sequencing FSM: latch the state, feed 16 bytes, wait for the last result, pulse done.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            r_state  <= ST_IDLE;
            r_in_cnt <= 4'd0;
            r_in     <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (StartxSI) begin
                        r_in     <= StatexDI;
                        r_in_cnt <= 4'd0;
                        r_ready  <= 1'b0;
                        r_state  <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    // Counter parks at 15 instead of wrapping; it is reloaded on the next start.
                    if (r_in_cnt == 4'(NUM_BYTES - 1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_in_cnt <= r_in_cnt + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_vld_tap && (r_out_cnt == 4'(NUM_BYTES - 1))) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result capture runs off the valid tap alone, independent of the FSM state.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            r_res     <= '0;
            r_out_cnt <= 4'd0;
        end else if (w_accept) begin
            r_out_cnt <= 4'd0;
        end else if (w_vld_tap) begin
            for (int s = 0; s < SHARES; s++) begin
                r_res[byte_lsb(s, int'(r_out_cnt)) +: 8] <= SboxQxDI[8*s +: 8];
            end
            if (r_out_cnt != 4'(NUM_BYTES - 1)) begin
                r_out_cnt <= r_out_cnt + 4'd1;
            end
        end
    end

    // Sbox input mux: current byte of every share while feeding, zero otherwise.
    always_comb begin
        SboxXxDO = '0;
        if (r_state == ST_FEED) begin
            for (int s = 0; s < SHARES; s++) begin
                SboxXxDO[8*s +: 8] = r_in[byte_lsb(s, int'(r_in_cnt)) +: 8];
            end
        end
    end

    assign ReadyxSO = r_ready;
    assign DonexSO  = r_done;
    assign StatexDO = r_res;
    assign RndEnxSO = (r_state == ST_FEED) || w_vld_any;

endmodule
